median_window_gen: RTL

Streaming 3x3 neighbourhood generator directly upstream of the median filter stage. Accepts a raster-order 8-bit pixel stream for one image (default 64x64) and emits, for every pixel, its nine-pixel window plus position and border flag, ready for the median sorter. The block uses two line buffers and a 3x3 register array, and drains the last row automatically at end of frame.

---
 rtl/median_window_gen.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/median_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the median sorter (raster 8-bit pixels in, 9-tap window out).
// Latency: window for beat p is registered the cycle after beat p+WIDTH+1 is accepted; flush drains the last row.
// Backpressure: in_ready drops for WIDTH+1 cycles at end of frame while zero beats are injected; no output stall.
module median_window_gen #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_pixel,
  output logic          in_ready,
  output logic          out_valid,
  output logic [71:0]   out_window,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_border,
  output logic          frame_done
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam int            FW     = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] F_LAST = FW'(WIDTH);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Input-side raster position (drives line-buffer addressing and FSM transitions)
  logic [XW-1:0] r_ix;
  logic [YW-1:0] r_iy;
  // Position of the centre pixel of the next window to be emitted
  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  // Number of zero beats already injected during FLUSH
  logic [FW-1:0] r_fcnt;

  // Line buffers: lb0 holds the row above the incoming pixel, lb1 the row above that
  logic [7:0]    r_lb0 [WIDTH];
  logic [7:0]    r_lb1 [WIDTH];
  // Raw (unmasked) 3x3 window; index k = 3*row + col, row 0 is the oldest line
  logic [7:0]    r_win [9];

  logic          w_beat;
  logic          w_emit;
  logic [7:0]    w_pix;
  logic          w_fill_done;
  logic          w_in_last;
  logic          w_flush_last;
  logic          w_clear;
  logic [7:0]    w_lb0_rd;
  logic [7:0]    w_lb1_rd;
  logic [7:0]    w_win_nxt [9];
  logic [71:0]   w_win_masked;
  logic          w_ox_first;
  logic          w_ox_last;
  logic          w_oy_first;
  logic          w_oy_last;

  assign w_fill_done  = (r_ix == '0) && (r_iy == YW'(1));
  assign w_in_last    = (r_ix == X_LAST) && (r_iy == Y_LAST);
  assign w_flush_last = (r_fcnt == F_LAST);
  assign w_clear      = (r_state == FLUSH) && w_flush_last;

  assign w_lb0_rd     = r_lb0[r_ix];
  assign w_lb1_rd     = r_lb1[r_ix];

  assign w_ox_first   = (r_ox == '0);
  assign w_ox_last    = (r_ox == X_LAST);
  assign w_oy_first   = (r_oy == '0);
  assign w_oy_last    = (r_oy == Y_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, ready, and per-cycle beat/emit decode (zero beats injected in FLUSH)
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    w_beat      = 1'b0;
    w_emit      = 1'b0;
    w_pix       = in_pixel;
    case (r_state)
      FILL: begin
        w_beat = in_valid;
        if (in_valid && w_fill_done) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_beat = in_valid;
        w_emit = in_valid;
        if (in_valid && w_in_last) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        in_ready = 1'b0;
        w_beat   = 1'b1;
        w_emit   = 1'b1;
        w_pix    = 8'd0;
        if (w_flush_last) begin
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // Input raster counters; flush beats keep counting so the line buffers stay addressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ix <= '0;
      r_iy <= '0;
    end else if (w_clear) begin
      r_ix <= '0;
      r_iy <= '0;
    end else if (w_beat) begin
      if (r_ix == X_LAST) begin
        r_ix <= '0;
        r_iy <= (r_iy == Y_LAST) ? '0 : r_iy + YW'(1);
      end else begin
        r_ix <= r_ix + XW'(1);
      end
    end
  end

  // Count injected zero beats while flushing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fcnt <= '0;
    end else if (r_state == FLUSH) begin
      r_fcnt <= w_flush_last ? '0 : r_fcnt + FW'(1);
    end else begin
      r_fcnt <= '0;
    end
  end

  // Next raw window: shift left one column, new right column from both line buffers and the pixel
  always_comb begin
    w_win_nxt[0] = r_win[1];
    w_win_nxt[1] = r_win[2];
    w_win_nxt[2] = w_lb1_rd;
    w_win_nxt[3] = r_win[4];
    w_win_nxt[4] = r_win[5];
    w_win_nxt[5] = w_lb0_rd;
    w_win_nxt[6] = r_win[7];
    w_win_nxt[7] = r_win[8];
    w_win_nxt[8] = w_pix;
  end

  // Line buffers and raw window are data-only; stale contents are always masked or overwritten
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_lb0[r_ix] <= w_pix;
      r_lb1[r_ix] <= w_lb0_rd;
      r_win       <= w_win_nxt;
    end
  end

  // Zero the taps that fall outside the image for the centre being emitted
  always_comb begin
    w_win_masked = '0;
    for (int k = 0; k < 9; k++) begin
      if (!((k % 3 == 0) && w_ox_first) &&
          !((k % 3 == 2) && w_ox_last)  &&
          !((k / 3 == 0) && w_oy_first) &&
          !((k / 3 == 2) && w_oy_last)) begin
        w_win_masked[8*k +: 8] = w_win_nxt[k];
      end
    end
  end

  // Output-side centre position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ox <= '0;
      r_oy <= '0;
    end else if (w_clear) begin
      r_ox <= '0;
      r_oy <= '0;
    end else if (w_emit) begin
      if (w_ox_last) begin
        r_ox <= '0;
        r_oy <= w_oy_last ? '0 : r_oy + YW'(1);
      end else begin
        r_ox <= r_ox + XW'(1);
      end
    end
  end

  // Registered window outputs; frame_done marks the last centre of the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_border <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= w_emit;
      frame_done <= w_emit && w_ox_last && w_oy_last;
      if (w_emit) begin
        out_window <= w_win_masked;
        out_x      <= r_ox;
        out_y      <= r_oy;
        out_border <= w_ox_first || w_ox_last || w_oy_first || w_oy_last;
      end
    end
  end

endmodule
